sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares one single-ported synchronous SRAM between the instruction-fetch and load/store requesters of the five-stage core. It grants at most one access per cycle and routes the one-cycle-late read data back to the access owner. It also discards in-flight fetch responses on an exception or ertn flush. It sits between the IF/EX stages and the unified memory port, taking over from the separate inst/data SRAM ports.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte strobes are DATA_W/8 = 4)

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- inst_req  in  1  fetch request; held with its fields stable until inst_addr_ok
- inst_wr  in  1  write flag (0 for fetch; honoured anyway)
- inst_wstrb  in  4  byte strobes
- inst_addr  in  ADDR_W  address
- inst_wdata  in  DATA_W  write data
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  response pulse
- inst_rdata  out  DATA_W  read data, valid with inst_data_ok
- data_req, data_wr, data_wstrb, data_addr, data_wdata  in  same widths as inst_*  load/store request
- data_addr_ok, data_data_ok, data_rdata  out  same widths as inst_*  load/store handshake
- flush  in  1  excp_flush | ertn_flush from WB
- sram_en  out  1  SRAM enable
- sram_we  out  4  byte write enables
- sram_addr  out  ADDR_W  SRAM address
- sram_wdata  out  DATA_W  SRAM write data
- sram_rdata  in  DATA_W  SRAM read data, one cycle after sram_en

## Operation
- Grant is combinational each cycle, with candidates inst_req & ~flush and data_req.
  - Only one candidate: it wins.
  - Both: data wins (fixed priority), or the policy selected under Configuration applies.
  - While reset is asserted, no grant is issued.
- On a grant:
  - sram_en = 1.
  - sram_we = wr ? wstrb : 4'h0.
  - addr/wdata are muxed from the winner.
  - The winner's addr_ok = 1 in the same cycle. The loser's addr_ok = 0 and it keeps requesting.
- No grant: sram_en = 0, sram_we = 0. sram_addr and sram_wdata are don't-care; the implementation drives the data-side fields.
- Response registers, updated every cycle:
  - rsp_valid <= grant.
  - rsp_owner <= winner (0 = INST, 1 = DATA).
  - rsp_kill <= flush & (winner == INST).
- Response cycle, with rsp_valid = 1:
  - Owner DATA: data_data_ok = 1, data_rdata = sram_rdata.
  - Owner INST: inst_data_ok = ~(rsp_kill | flush), inst_rdata = sram_rdata.
- Writes also return data_ok. Rdata is don't-care for writes.
- Flush never affects data-side traffic. A data access in flight completes normally.
- Reset values:
  - rsp_valid = 0, rsp_owner = INST, rsp_kill = 0, last_grant = INST.
  - All outputs are 0 during reset: sram_en, sram_we, both addr_ok and both data_ok.
- Reset mid-operation: any in-flight response is dropped and no data_ok is produced afterwards for it.

## Timing
- Request accepted in cycle T (addr_ok). Its data_ok and rdata appear in T+1.
- Throughput is one access per cycle. A new grant may coincide with the previous data_ok, on either side.
- Both requesting continuously under fixed priority: data is granted every cycle and inst starves. Starvation freedom is only provided under Configuration.
- Flush in cycle T blocks a new inst grant in T. It also suppresses an inst response due in T or T+1.

## Configuration
- SRAM_ARB_RR_EN defined:
  - Round-robin on conflict: the requester not equal to last_grant wins.
  - last_grant is updated on every grant.
  - Worst-case wait is 1 cycle.
- SRAM_ARB_RR_EN undefined:
  - Fixed data-over-inst priority.
  - The last_grant register is not implemented.

## Structure
- Package sram_arb_pkg:
  - owner_t enum: OWN_INST = 1'b0, OWN_DATA = 1'b1.
  - Constants ADDR_W, DATA_W, STRB_W.
- Sub-module sram_arb_pick:
  - Combinational 2-way pick with optional last_grant input.
  - Keeps policy code isolated from the datapath mux and response registers.
- Top: grant mux, response registers (rsp_valid, rsp_owner, rsp_kill), data_ok/rdata routing.

## Test plan
- Single fetch at 0x1c000000 with SRAM holding 0x02800c0c:
  - T: inst_addr_ok=1, sram_en=1, sram_we=0.
  - T+1: inst_data_ok=1, inst_rdata=0x02800c0c.
- Simultaneous inst_req and data_req (store 0x00000010, wstrb 4'hF, wdata 0xdeadbeef), fixed priority:
  - Data is granted in T with sram_we=4'hF.
  - Inst is granted in T+1.
  - data_data_ok appears in T+1 and inst_data_ok in T+2.
- Same conflict held for 4 cycles with SRAM_ARB_RR_EN defined:
  - Grants alternate DATA, INST, DATA, INST.
  - No requester waits more than 1 cycle.
- Fetch granted in T with flush=1 in T+1:
  - inst_data_ok stays 0.
  - A data load granted in T+1 still returns data_data_ok in T+2.
- Flush=1 with inst_req=1 and no data_req:
  - sram_en=0 and inst_addr_ok=0 that cycle.
  - Grant issues the next cycle after flush drops.
- Reset asserted asynchronously in the cycle after a grant:
  - All outputs go to 0 immediately.
  - No data_ok is seen after reset releases until a new request is accepted.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the unified SRAM arbiter.
// Round-robin arbitration is enabled by defining SRAM_ARB_RR_EN.
package sram_arb_pkg;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

endpackage

// File: rtl/sram_arb_pick.sv
// Two-way requester pick: fixed data-over-inst priority, or round-robin on
// conflict when SRAM_ARB_RR_EN is defined.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic inst_cand,
  input  logic data_cand,
`ifdef SRAM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant,
  output logic winner
);

  always_comb begin
    grant  = inst_cand | data_cand;
    winner = OWN_DATA;
    if (inst_cand && !data_cand) begin
      winner = OWN_INST;
    end
`ifdef SRAM_ARB_RR_EN
    // On conflict the side that did not win last time goes first.
    else if (inst_cand && data_cand && (last_grant == OWN_DATA)) begin
      winner = OWN_INST;
    end
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one single-ported synchronous SRAM between fetch and load/store.
// Define SRAM_ARB_RR_EN for round-robin conflict resolution.
module sram_arbiter
  import sram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,

  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [STRB_W-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  input  logic              data_req,
  input  logic              data_wr,
  input  logic [STRB_W-1:0] data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  input  logic              flush,

  output logic              sram_en,
  output logic [STRB_W-1:0] sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  logic   inst_cand;
  logic   data_cand;
  logic   grant;
  logic   winner;
  logic   pick_inst;
  logic   pick_data;

  logic   rsp_valid_p1;
  owner_t rsp_owner_p1;
  logic   rsp_kill_p1;

  // A flushed fetch must not even be issued; reset blocks every grant.
  assign inst_cand = inst_req & ~flush & ~reset;
  assign data_cand = data_req & ~reset;

`ifdef SRAM_ARB_RR_EN
  logic last_grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= OWN_INST;
    end else if (grant) begin
      last_grant <= winner;
    end
  end
`endif

  sram_arb_pick u_pick (
    .inst_cand  (inst_cand),
    .data_cand  (data_cand),
`ifdef SRAM_ARB_RR_EN
    .last_grant (last_grant),
`endif
    .grant      (grant),
    .winner     (winner)
  );

  assign pick_inst = grant & (winner == OWN_INST);
  assign pick_data = grant & (winner == OWN_DATA);

  // ---- stage p0: request mux onto the SRAM port ----
  always_comb begin
    sram_en = grant;
    if (pick_inst) begin
      sram_addr  = inst_addr;
      sram_wdata = inst_wdata;
      sram_we    = inst_wr ? inst_wstrb : {STRB_W{1'b0}};
    end else begin
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
      sram_we    = (pick_data && data_wr) ? data_wstrb : {STRB_W{1'b0}};
    end
  end

  assign inst_addr_ok = pick_inst;
  assign data_addr_ok = pick_data;

  // ---- stage p1: response tracking, aligned with SRAM read data ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_p1 <= 1'b0;
      rsp_owner_p1 <= OWN_INST;
      rsp_kill_p1  <= 1'b0;
    end else begin
      rsp_valid_p1 <= grant;
      rsp_owner_p1 <= owner_t'(winner);
      rsp_kill_p1  <= flush & (winner == OWN_INST);
    end
  end

  // Flush in the response cycle still cancels a fetch that was issued before it.
  assign data_data_ok = ~reset & rsp_valid_p1 & (rsp_owner_p1 == OWN_DATA);
  assign inst_data_ok = ~reset & rsp_valid_p1 & (rsp_owner_p1 == OWN_INST)
                        & ~(rsp_kill_p1 | flush);
  assign inst_rdata   = sram_rdata;
  assign data_rdata   = sram_rdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr, flush;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .flush(flush),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Synchronous single-port SRAM: read-before-write, data one cycle later.
  always @(posedge clk) begin
    if (sram_en) begin
      sram_rdata <= mem[sram_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) mem[sram_addr[9:2]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
    end
  end

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    inst_req = 1; data_req = 1; data_wr = 1; data_wstrb = 4'hF;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if ({sram_en, sram_we, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b we=%h iaok=%b daok=%b idok=%b ddok=%b expected all 0",
               sram_en, sram_we, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok);
    end
    tick();
    idle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({inst_data_ok, data_data_ok, sram_en} !== 3'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got idok=%b ddok=%b en=%b expected 0",
               inst_data_ok, data_data_ok, sram_en);
    end
  endtask

  task automatic test_fetch();
    tick();
    inst_req = 1; inst_addr = 32'h1c000000;
    @(negedge clk);
    checks++;
    if ({inst_addr_ok, sram_en, sram_we} !== {1'b1, 1'b1, 4'h0}) begin
      errors++;
      $display("FAIL fetch_issue: got aok=%b en=%b we=%h expected 1 1 0", inst_addr_ok, sram_en, sram_we);
    end
    checks++;
    if (sram_addr !== 32'h1c000000) begin
      errors++;
      $display("FAIL fetch_addr: got %h expected 1c000000", sram_addr);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h02800c0c) begin
      errors++;
      $display("FAIL fetch_resp: got dok=%b rdata=%h expected 1 02800c0c", inst_data_ok, inst_rdata);
    end
    checks++;
    if (data_data_ok !== 1'b0) begin
      errors++;
      $display("FAIL fetch_no_data_ok: got %b expected 0", data_data_ok);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] exp_i;
    exp_i = mem[1];
    tick();
    inst_req = 1; inst_addr = 32'h1c000004;
    data_req = 1; data_wr = 1; data_wstrb = 4'hF; data_addr = 32'h10; data_wdata = 32'hdeadbeef;
    @(negedge clk);
    checks++;
    if ({data_addr_ok, inst_addr_ok, sram_we} !== {1'b1, 1'b0, 4'hF}) begin
      errors++;
      $display("FAIL conflict_t0: got daok=%b iaok=%b we=%h expected 1 0 f", data_addr_ok, inst_addr_ok, sram_we);
    end
    tick();
    data_req = 0; data_wr = 0; data_wstrb = 0;
    @(negedge clk);
    checks++;
    if ({inst_addr_ok, data_data_ok, inst_data_ok, sram_we} !== {1'b1, 1'b1, 1'b0, 4'h0}) begin
      errors++;
      $display("FAIL conflict_t1: got iaok=%b ddok=%b idok=%b we=%h expected 1 1 0 0",
               inst_addr_ok, data_data_ok, inst_data_ok, sram_we);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== exp_i) begin
      errors++;
      $display("FAIL conflict_t2: got idok=%b ddok=%b rdata=%h expected 1 0 %h",
               inst_data_ok, data_data_ok, inst_rdata, exp_i);
    end
    checks++;
    if (mem[4] !== 32'hdeadbeef) begin
      errors++;
      $display("FAIL conflict_store: got %h expected deadbeef", mem[4]);
    end
  endtask

  task automatic test_arbitration();
    logic exp_data [4];
`ifdef SRAM_ARB_RR_EN
    exp_data = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_data = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    tick();
    inst_req = 1; inst_addr = 32'h1c000008;
    data_req = 1; data_addr = 32'h20;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (data_addr_ok !== exp_data[c] || inst_addr_ok !== !exp_data[c]) begin
        errors++;
        $display("FAIL arb_cycle%0d: got daok=%b iaok=%b expected daok=%b", c, data_addr_ok,
                 inst_addr_ok, exp_data[c]);
      end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_flush();
    tick();
    inst_req = 1; inst_addr = 32'h1c00000c;
    @(negedge clk);
    checks++;
    if (inst_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL flush_fetch_issue: got %b expected 1", inst_addr_ok);
    end
    tick();
    inst_req = 0; flush = 1; data_req = 1; data_addr = 32'h10;
    @(negedge clk);
    checks++;
    if ({inst_data_ok, data_addr_ok} !== 2'b01) begin
      errors++;
      $display("FAIL flush_kill: got idok=%b daok=%b expected 0 1", inst_data_ok, data_addr_ok);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if ({data_data_ok, inst_data_ok} !== 2'b10 || data_rdata !== 32'hdeadbeef) begin
      errors++;
      $display("FAIL flush_data_resp: got ddok=%b idok=%b rdata=%h expected 1 0 deadbeef",
               data_data_ok, inst_data_ok, data_rdata);
    end
    tick();
    flush = 1; inst_req = 1; inst_addr = 32'h1c000010;
    @(negedge clk);
    checks++;
    if ({sram_en, inst_addr_ok} !== 2'b00) begin
      errors++;
      $display("FAIL flush_block: got en=%b iaok=%b expected 0 0", sram_en, inst_addr_ok);
    end
    tick();
    flush = 0;
    @(negedge clk);
    checks++;
    if ({sram_en, inst_addr_ok} !== 2'b11) begin
      errors++;
      $display("FAIL flush_release: got en=%b iaok=%b expected 1 1", sram_en, inst_addr_ok);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (inst_data_ok !== 1'b1 || inst_rdata !== mem[4]) begin
      errors++;
      $display("FAIL flush_release_resp: got dok=%b rdata=%h expected 1 %h", inst_data_ok, inst_rdata, mem[4]);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    data_req = 1; data_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (data_addr_ok !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_issue: got %b expected 1", data_addr_ok);
    end
    tick();
    data_req = 0; inst_req = 1; inst_addr = 32'h1c000000;
    #1;
    checks++;
    if (data_data_ok !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pending: got %b expected 1", data_data_ok);
    end
    inst_req = 0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({sram_en, sram_we, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 9'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got en=%b we=%h iaok=%b daok=%b idok=%b ddok=%b expected all 0",
               sram_en, sram_we, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({inst_data_ok, data_data_ok} !== 2'b00) begin
        errors++;
        $display("FAIL rstmid_after%0d: got idok=%b ddok=%b expected 0 0", c, inst_data_ok, data_data_ok);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [256];
    logic        pv, pown, prd, pkill, lg, hi, hd;
    logic        ic, dc, g, win, e_iok, e_dok;
    logic [31:0] pdat, eaddr, ewd;
    logic [3:0]  ewe;
    logic [7:0]  idx;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    pv = 0; pown = 0; prd = 0; pkill = 0; pdat = 0; lg = OWN_INST; hi = 0; hd = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (!hi) begin
        inst_req = ($urandom_range(0, 9) < 7); inst_wr = ($urandom_range(0, 3) == 0);
        inst_wstrb = 4'($urandom); inst_addr = $urandom; inst_wdata = $urandom;
      end
      if (!hd) begin
        data_req = ($urandom_range(0, 9) < 5); data_wr = $urandom_range(0, 1) == 1;
        data_wstrb = 4'($urandom); data_addr = $urandom; data_wdata = $urandom;
      end
      flush = ($urandom_range(0, 9) == 0);
      @(negedge clk);
      ic = inst_req & ~flush;
      dc = data_req;
      g  = ic | dc;
`ifdef SRAM_ARB_RR_EN
      win = (ic && dc) ? ~lg : dc;
`else
      win = dc;
`endif
      eaddr = win ? data_addr : inst_addr;
      ewd   = win ? data_wdata : inst_wdata;
      ewe   = !g ? 4'h0 : (win ? (data_wr ? data_wstrb : 4'h0) : (inst_wr ? inst_wstrb : 4'h0));
      e_iok = pv && !pown && !pkill && !flush;
      e_dok = pv && pown;
      checks++;
      if ({sram_en, inst_addr_ok, data_addr_ok, sram_we} !== {g, g && !win, g && win, ewe}) begin
        errors++;
        $display("FAIL rand_grant c%0d: got en=%b iaok=%b daok=%b we=%h expected %b %b %b %h", c,
                 sram_en, inst_addr_ok, data_addr_ok, sram_we, g, g && !win, g && win, ewe);
      end
      if (g) begin
        checks++;
        if (sram_addr !== eaddr || (ewe != 0 && sram_wdata !== ewd)) begin
          errors++;
          $display("FAIL rand_bus c%0d: got addr=%h wdata=%h expected %h %h", c, sram_addr, sram_wdata, eaddr, ewd);
        end
      end
      checks++;
      if ({inst_data_ok, data_data_ok} !== {e_iok, e_dok}) begin
        errors++;
        $display("FAIL rand_dok c%0d: got idok=%b ddok=%b expected %b %b", c, inst_data_ok, data_data_ok, e_iok, e_dok);
      end
      if (pv && prd && (e_iok || e_dok)) begin
        checks++;
        if ((e_dok ? data_rdata : inst_rdata) !== pdat) begin
          errors++;
          $display("FAIL rand_rdata c%0d: got %h expected %h", c, e_dok ? data_rdata : inst_rdata, pdat);
        end
      end
      pv = g;
      if (g) begin
        idx   = eaddr[9:2];
        pdat  = ref_mem[idx];
        for (int b = 0; b < 4; b++)
          if (ewe[b]) ref_mem[idx][b*8 +: 8] = ewd[b*8 +: 8];
        prd   = !(win ? data_wr : inst_wr);
        pown  = win;
        pkill = flush && !win;
        lg    = win;
      end
      hi = inst_req && !(g && !win);
      hd = data_req && !(g && win);
    end
    tick();
    idle();
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h02800c0c;
    test_reset();
    test_fetch();
    test_conflict();
    test_arbitration();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
